// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI slave physical layer.
package spi_slave_pkg;

    localparam int SPI_BYTE_W        = 8;
    localparam int SPI_BITS_PER_BYTE = 8;
    localparam int SPI_CNT_W         = $clog2(SPI_BITS_PER_BYTE);

    typedef logic [SPI_BYTE_W-1:0] spi_byte_t;
    typedef logic [SPI_CNT_W-1:0]  spi_cnt_t;

    localparam spi_byte_t SPI_IDLE_BYTE = 8'hFF;
    localparam spi_cnt_t  SPI_LAST_BIT  = spi_cnt_t'(SPI_BITS_PER_BYTE - 1);

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous input, with single-cycle rise/fall pulses
// derived from the last stage and a one-cycle delayed copy of it.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~dly_q;
    assign fall  = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/simple_spi_slave_phy.sv
// SPI mode-0 slave PHY, MSB first, oversampled in the clk domain.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float MISO while chip select is high.
module simple_spi_slave_phy
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOAD_DELAY  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SPI_BYTE_W-1:0] i_tx_byte,
    input  logic                  i_tx_ready,
    output logic [SPI_BYTE_W-1:0] o_rx_byte,
    output logic                  o_byte_received,
    output logic                  o_req_next_byte,
    input  logic                  i_spi_clk,
    input  logic                  i_spi_cs_n,
    input  logic                  i_spi_mosi,
    output logic                  o_spi_miso
);

    localparam int LD_W = $clog2(LOAD_DELAY + 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .async_in(i_spi_clk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .async_in(i_spi_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .async_in(i_spi_mosi),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_cnt_t        bit_cnt;
    spi_byte_t       rx_shift;
    spi_byte_t       tx_shift;
    logic [LD_W-1:0] load_cnt;

    logic cs_active, shift_in, shift_out, byte_done, req_set, tx_load;

    // A CS rise leaves cs_level high, so it also masks any SCLK edge of the same cycle.
    assign cs_active = ~cs_level;
    assign shift_in  = sclk_rise & cs_active;
    assign shift_out = sclk_fall & cs_active & (bit_cnt != '0);
    assign byte_done = shift_in & (bit_cnt == SPI_LAST_BIT);
    assign req_set   = cs_fall | byte_done;
    assign tx_load   = cs_active & (load_cnt == LD_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt         <= '0;
            rx_shift        <= '0;
            o_rx_byte       <= '0;
            o_byte_received <= 1'b0;
            o_req_next_byte <= 1'b0;
        end else begin
            o_byte_received <= 1'b0;
            o_req_next_byte <= req_set;
            if (cs_rise || cs_fall) begin
                bit_cnt <= '0;
            end else if (shift_in) begin
                rx_shift <= {rx_shift[SPI_BYTE_W-2:0], mosi_level};
                if (byte_done) begin
                    bit_cnt         <= '0;
                    o_rx_byte       <= {rx_shift[SPI_BYTE_W-2:0], mosi_level};
                    o_byte_received <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + spi_cnt_t'(1);
                end
            end
        end
    end

    // The load countdown starts on the same edge that raises o_req_next_byte,
    // so the handler's byte is sampled LOAD_DELAY cycles after the pulse is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt <= '0;
            tx_shift <= SPI_IDLE_BYTE;
        end else if (cs_rise) begin
            load_cnt <= '0;
            tx_shift <= SPI_IDLE_BYTE;
        end else begin
            if (req_set) begin
                load_cnt <= LD_W'(LOAD_DELAY);
            end else if (load_cnt != '0) begin
                load_cnt <= load_cnt - LD_W'(1);
            end

            if (tx_load) begin
                tx_shift <= i_tx_ready ? i_tx_byte : SPI_IDLE_BYTE;
            end else if (shift_out) begin
                tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b1};
            end
        end
    end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign o_spi_miso = cs_level ? 1'bz : tx_shift[SPI_BYTE_W-1];
`else
    assign o_spi_miso = cs_level ? 1'b1 : tx_shift[SPI_BYTE_W-1];
`endif

endmodule

// File: tb/tb_simple_spi_slave_phy.sv
// Scoreboard bench for simple_spi_slave_phy: stimulus pushes expected rx and MISO bytes,
// independent monitors pop and compare when the DUT completes a byte.
module tb_simple_spi_slave_phy;

    localparam int HALF = 10;

    typedef struct packed {
        logic       rdy;
        logic [7:0] data;
    } plan_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_tx_byte = 8'h00;
    logic       i_tx_ready = 1'b0;
    logic [7:0] o_rx_byte;
    logic       o_byte_received;
    logic       o_req_next_byte;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       o_spi_miso;

    int total = 0;
    int bad = 0;
    int n_rx = 0;
    int n_req = 0;

    plan_t      plan_q[$];
    logic [7:0] rx_exp_q[$];
    logic [7:0] miso_exp_q[$];

    logic       miso_idle;

    simple_spi_slave_phy dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_tx_byte      (i_tx_byte),
        .i_tx_ready     (i_tx_ready),
        .o_rx_byte      (o_rx_byte),
        .o_byte_received(o_byte_received),
        .o_req_next_byte(o_req_next_byte),
        .i_spi_clk      (spi_sclk),
        .i_spi_cs_n     (spi_cs_n),
        .i_spi_mosi     (spi_mosi),
        .o_spi_miso     (o_spi_miso)
    );

    always #5 clk = ~clk;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    initial miso_idle = 1'bz;
`else
    initial miso_idle = 1'b1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7 - i];
            wait_clk(HALF);
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    // Handler model: answers each request with the next planned byte, or not-ready if none.
    always @(negedge clk) begin
        if (o_req_next_byte) begin
            n_req++;
            if (plan_q.size() != 0) begin
                plan_t p;
                p = plan_q.pop_front();
                i_tx_ready = p.rdy;
                i_tx_byte  = p.data;
            end else begin
                i_tx_ready = 1'b0;
                i_tx_byte  = 8'h00;
            end
        end
    end

    // Rx monitor.
    always @(negedge clk) begin
        if (o_byte_received) begin
            n_rx++;
            if (rx_exp_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
            else                      check("rx_byte", 32'(o_rx_byte), 32'(rx_exp_q.pop_front()));
        end
    end

    // MISO monitor: samples as the master does, on SCLK rise; a CS rise discards partial bytes.
    logic [7:0] m_shift = 8'h00;
    int         m_bits = 0;
    always @(posedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            m_bits = 0;
        end else begin
            m_shift = {m_shift[6:0], o_spi_miso};
            m_bits++;
            if (m_bits == 8) begin
                m_bits = 0;
                if (miso_exp_q.size() == 0) check("miso_unexpected", 32'd1, 32'd0);
                else                        check("miso_byte", 32'(m_shift), 32'(miso_exp_q.pop_front()));
            end
        end
    end

    int req0;
    int rx0;

    initial begin
        wait_clk(3);
        check("rst_rx_byte", 32'(o_rx_byte), 32'h00);
        check("rst_rx_pulse", 32'(o_byte_received), 32'd0);
        check("rst_req", 32'(o_req_next_byte), 32'd0);
        check("rst_miso", 32'(o_spi_miso), 32'(miso_idle));
        rst_n = 1'b1;
        wait_clk(5);

        // Single byte: A5 out, 3C in.
        req0 = n_req;
        plan_q.push_back('{1'b1, 8'hA5});
        miso_exp_q.push_back(8'hA5);
        rx_exp_q.push_back(8'h3C);
        cs_begin();
        send_bits(8'h3C, 8);
        cs_end();
        check("single_req_count", 32'(n_req - req0), 32'd2);

        // Two back-to-back bytes.
        req0 = n_req;
        plan_q.push_back('{1'b1, 8'hC3});
        plan_q.push_back('{1'b1, 8'h5A});
        miso_exp_q.push_back(8'hC3);
        miso_exp_q.push_back(8'h5A);
        rx_exp_q.push_back(8'h11);
        rx_exp_q.push_back(8'h22);
        cs_begin();
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        cs_end();
        check("burst_req_count", 32'(n_req - req0), 32'd3);

        // Handler not ready: idle byte goes out.
        plan_q.push_back('{1'b0, 8'h77});
        miso_exp_q.push_back(8'hFF);
        rx_exp_q.push_back(8'h96);
        cs_begin();
        send_bits(8'h96, 8);
        cs_end();

        // Abort after 5 bits, then a clean byte.
        rx0 = n_rx;
        plan_q.push_back('{1'b1, 8'hE7});
        cs_begin();
        send_bits(8'h81, 5);
        cs_end();
        check("abort_no_pulse", 32'(n_rx - rx0), 32'd0);
        check("abort_rx_held", 32'(o_rx_byte), 32'h96);
        plan_q.push_back('{1'b1, 8'h3C});
        miso_exp_q.push_back(8'h3C);
        rx_exp_q.push_back(8'h81);
        cs_begin();
        send_bits(8'h81, 8);
        cs_end();

        // SCLK activity with CS high is ignored.
        rx0  = n_rx;
        req0 = n_req;
        for (int i = 0; i < 8; i++) begin
            spi_mosi = i[0];
            wait_clk(HALF);
            spi_sclk = 1'b1;
            wait_clk(HALF);
            check("cs_high_miso", 32'(o_spi_miso), 32'(miso_idle));
            spi_sclk = 1'b0;
        end
        wait_clk(HALF);
        check("cs_high_no_rx", 32'(n_rx - rx0), 32'd0);
        check("cs_high_no_req", 32'(n_req - req0), 32'd0);

        // Reset mid-transfer, then F0 received intact.
        plan_q.push_back('{1'b1, 8'h55});
        cs_begin();
        send_bits(8'hF0, 4);
        rst_n = 1'b0;
        #1;
        check("midrst_rx_byte", 32'(o_rx_byte), 32'h00);
        check("midrst_rx_pulse", 32'(o_byte_received), 32'd0);
        check("midrst_req", 32'(o_req_next_byte), 32'd0);
        check("midrst_miso", 32'(o_spi_miso), 32'(miso_idle));
        wait_clk(3);
        spi_cs_n = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        plan_q.push_back('{1'b1, 8'h0F});
        miso_exp_q.push_back(8'h0F);
        rx_exp_q.push_back(8'hF0);
        cs_begin();
        send_bits(8'hF0, 8);
        cs_end();
        check("final_rx_byte", 32'(o_rx_byte), 32'hF0);

        check("rx_total", 32'(n_rx), 32'd6);
        check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);
        check("miso_queue_drained", 32'(miso_exp_q.size()), 32'd0);
        check("plan_queue_drained", 32'(plan_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
